// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

   localparam int          PC_WIDTH         = 32;
   localparam int          INST_WIDTH       = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One prefetch queue entry: the instruction and the PC it was fetched from.
   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [INST_WIDTH-1:0] inst;
   } fetch_entry_t;

   // Fetch addresses are always word aligned.
   function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
      return {pc[PC_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: small synchronous FIFO of {pc, inst} entries with flush.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head is masked while empty so stale storage never leaks onto the outputs.
   assign head = empty ? '0 : mem[rd_ptr];

   // Entry storage.
   // NOTE: storage is deliberately not reset; validity is tracked by count, and the head mask covers the empty case.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping; flush discards everything at once.
   // NOTE: all sequential state uses <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// stale-response dropping after redirects, and the IF/ID handshake.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop;
   logic [CW-1:0] q_count;
   logic          q_empty;
   logic          q_full;
   fetch_entry_t  q_head;
   fetch_entry_t  q_push_data;
   logic          req_fire;
   logic          keep;
   logic          pop;

   // Credit rule: queued plus outstanding never exceeds the queue depth,
   // so every response always has a slot waiting for it.
   assign imem_req_valid = !rst && !redirect_valid && ((q_count + inflight) < CW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response is kept only when it is not stale and no redirect is flushing the queue.
   assign keep        = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign pop         = !q_empty && if_ready && !redirect_valid;
   assign q_push_data = '{pc: rsp_pc, inst: imem_rsp_data};

   assign if_valid = !q_empty;
   assign if_pc    = q_head.pc;
   assign if_inst  = q_head.inst;

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (keep),
      .push_data (q_push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (q_head),
      .count     (q_count),
      .empty     (q_empty),
      .full      (q_full)
   );

   // Request-side and response-side PCs; a redirect realigns both.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= align_pc(redirect_pc);
         rsp_pc   <= align_pc(redirect_pc);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + 32'd4;
         if (keep)     rsp_pc   <= rsp_pc + 32'd4;
      end
   end

   // Outstanding-request and stale-response counters. inflight already
   // includes earlier stale requests, so on a redirect every request still
   // outstanding after this cycle's response becomes stale.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
         if (redirect_valid)
            drop <= inflight - CW'(imem_rsp_valid);
         else if (imem_rsp_valid && (drop != '0))
            drop <= drop - CW'(1);
      end
   end

   a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (inflight != '0));

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      keep |-> (!q_full || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven streaming plus hand sequences
// for stall, redirects, wrap-around and mid-stream reset.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_ready;
   logic        if_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        req_valid, req_valid_w;
   logic [31:0] req_addr, req_addr_w;
   logic        rsp_valid, rsp_valid_w;
   logic [31:0] rsp_data, rsp_data_w;
   logic        if_valid, if_valid_w;
   logic [31:0] if_pc, if_inst, if_pc_w, if_inst_w;

   int checks   = 0;
   int failures = 0;
   bit mem_hold = 1'b0;

   logic [31:0]  pend[$];
   logic [31:0]  pend_w[$];
   logic [31:0]  issued[$];
   fetch_entry_t delivered[$];
   fetch_entry_t delivered_w[$];

   typedef struct {
      logic        if_ready;
      logic        exp_req_valid;
      logic [31:0] exp_req_addr;
      logic        exp_if_valid;
      logic [31:0] exp_if_pc;
   } vec_t;
   vec_t vecs[8];

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
      .clk(clk), .rst(rst),
      .imem_req_valid(req_valid_w), .imem_req_ready(req_ready), .imem_req_addr(req_addr_w),
      .imem_rsp_valid(rsp_valid_w), .imem_rsp_data(rsp_data_w),
      .if_valid(if_valid_w), .if_ready(if_ready), .if_pc(if_pc_w), .if_inst(if_inst_w),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, then advance the memory
   // models (in order, 1-cycle minimum latency, data = addr + 0x13).
   task automatic tick();
      logic acc, acc_w, rv, rv_w, dl, dl_w;
      logic [31:0] a, a_w;
      fetch_entry_t e, e_w;
      #1;
      acc   = req_valid && req_ready;     a   = req_addr;   rv   = rsp_valid;
      acc_w = req_valid_w && req_ready;   a_w = req_addr_w; rv_w = rsp_valid_w;
      dl    = if_valid && if_ready && !redirect_valid && !rst;
      dl_w  = if_valid_w && if_ready && !redirect_valid && !rst;
      e     = '{pc: if_pc, inst: if_inst};
      e_w   = '{pc: if_pc_w, inst: if_inst_w};
      @(posedge clk);
      #1;
      if (rst) begin
         pend.delete();
         pend_w.delete();
      end else begin
         if (rv && pend.size() > 0)     void'(pend.pop_front());
         if (rv_w && pend_w.size() > 0) void'(pend_w.pop_front());
         if (acc) begin
            pend.push_back(a);
            issued.push_back(a);
         end
         if (acc_w) pend_w.push_back(a_w);
      end
      if (dl)   delivered.push_back(e);
      if (dl_w) delivered_w.push_back(e_w);
      rsp_valid   = 1'b0; rsp_data   = '0;
      rsp_valid_w = 1'b0; rsp_data_w = '0;
      if (!rst && !mem_hold && pend.size() > 0) begin
         rsp_valid = 1'b1;
         rsp_data  = pend[0] + 32'h13;
      end
      if (!rst && !mem_hold && pend_w.size() > 0) begin
         rsp_valid_w = 1'b1;
         rsp_data_w  = pend_w[0] + 32'h13;
      end
   endtask

   task automatic clear_logs();
      issued.delete();
      delivered.delete();
      delivered_w.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; if_ready = 1'b1; mem_hold = 1'b0; req_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      clear_logs();
   endtask

   // Wait (bounded) until n instructions have been delivered by the main DUT.
   task automatic run_until_delivered(input int n, input string name);
      for (int i = 0; i < 40 && delivered.size() < n; i++) tick();
      check({name, "_count"}, delivered.size(), n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      // Cycle-by-cycle stream after reset: memory always ready, 1-cycle latency.
      vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};

      rst = 1'b1; req_ready = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; rsp_valid = 1'b0; rsp_data = '0; rsp_valid_w = 1'b0; rsp_data_w = '0;

      // Reset state.
      tick();
      tick();
      #1;
      check("rst_req_valid", req_valid, 1'b0);
      check("rst_req_addr", req_addr, 32'h0);
      check("rst_if_valid", if_valid, 1'b0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_inst", if_inst, 32'h0);
      check("rst_req_addr_wrap", req_addr_w, 32'hFFFF_FFF8);
      rst = 1'b0;
      clear_logs();

      // Table-driven stream; row 2 is the third cycle after release, first valid.
      for (int i = 0; i < 8; i++) begin
         if_ready = vecs[i].if_ready;
         #1;
         check($sformatf("row%0d_req_valid", i), req_valid, vecs[i].exp_req_valid);
         check($sformatf("row%0d_req_addr", i), req_addr, vecs[i].exp_req_addr);
         check($sformatf("row%0d_if_valid", i), if_valid, vecs[i].exp_if_valid);
         if (vecs[i].exp_if_valid) begin
            check($sformatf("row%0d_if_pc", i), if_pc, vecs[i].exp_if_pc);
            check($sformatf("row%0d_if_inst", i), if_inst, vecs[i].exp_if_pc + 32'h13);
         end
         tick();
      end

      // Wrap-around on the second instance, which saw the same stream.
      check("wrap_count_ge3", delivered_w.size() >= 3, 1'b1);
      if (delivered_w.size() >= 3) begin
         check("wrap_pc0", delivered_w[0].pc, 32'hFFFF_FFF8);
         check("wrap_pc1", delivered_w[1].pc, 32'hFFFF_FFFC);
         check("wrap_pc2", delivered_w[2].pc, 32'h0000_0000);
         check("wrap_inst2", delivered_w[2].inst, 32'h0000_0013);
      end

      // Stall: credit caps outstanding work at DEPTH, head holds.
      do_reset();
      if_ready = 1'b0;
      repeat (10) tick();
      #1;
      check("stall_issued", issued.size(), 2);
      if (issued.size() >= 2) begin
         check("stall_issue0", issued[0], 32'h0);
         check("stall_issue1", issued[1], 32'h4);
      end
      check("stall_if_valid", if_valid, 1'b1);
      check("stall_if_pc", if_pc, 32'h0);
      check("stall_if_inst", if_inst, 32'h0000_0013);
      check("stall_req_valid", req_valid, 1'b0);
      if_ready = 1'b1;
      run_until_delivered(3, "stall_release");
      if (delivered.size() >= 3) begin
         check("stall_pc0", delivered[0].pc, 32'h0);
         check("stall_pc1", delivered[1].pc, 32'h4);
         check("stall_inst1", delivered[1].inst, 32'h17);
         check("stall_pc2", delivered[2].pc, 32'h8);
      end
      if (issued.size() >= 3) check("stall_resume", issued[2], 32'h8);

      // Redirect with two requests outstanding: both responses are stale.
      do_reset();
      mem_hold = 1'b1;
      repeat (3) tick();
      #1;
      check("redir_outstanding", issued.size(), 2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      #1;
      check("redir_no_req", req_valid, 1'b0);
      tick();
      redirect_valid = 1'b0;
      mem_hold       = 1'b0;
      #1;
      check("redir_issued_same", issued.size(), 2);
      check("redir_if_valid", if_valid, 1'b0);
      check("redir_fetch_pc", req_addr, 32'h0000_0100);
      run_until_delivered(2, "redir");
      if (delivered.size() >= 2) begin
         check("redir_pc0", delivered[0].pc, 32'h0000_0100);
         check("redir_inst0", delivered[0].inst, 32'h0000_0113);
         check("redir_pc1", delivered[1].pc, 32'h0000_0104);
      end

      // Redirect coinciding with a response and a pop; target is realigned.
      do_reset();
      tick();
      tick();
      #1;
      check("redir2_head_valid", if_valid, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("redir2_if_valid", if_valid, 1'b0);
      check("redir2_req_valid", req_valid, 1'b1);
      check("redir2_req_addr", req_addr, 32'h0000_0200);
      run_until_delivered(2, "redir2");
      if (delivered.size() >= 2) begin
         check("redir2_pc0", delivered[0].pc, 32'h0000_0200);
         check("redir2_inst0", delivered[0].inst, 32'h0000_0213);
         check("redir2_pc1", delivered[1].pc, 32'h0000_0204);
         check("redir2_inst1", delivered[1].inst, 32'h0000_0217);
      end

      // Reset mid-stream with one entry queued and one request outstanding.
      do_reset();
      tick();
      tick();
      rst = 1'b1;
      tick();
      #1;
      check("mrst_if_valid", if_valid, 1'b0);
      check("mrst_req_valid", req_valid, 1'b0);
      check("mrst_req_addr", req_addr, 32'h0);
      rst = 1'b0;
      clear_logs();
      run_until_delivered(1, "mrst");
      if (delivered.size() >= 1) check("mrst_pc0", delivered[0].pc, 32'h0);
      if (issued.size() >= 1)    check("mrst_issue0", issued[0], 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
